// File: rtl/round_arbiter_pkg.sv
// Shared definitions for the reaction-game round arbiter: FSM state codes and
// the LFSR feedback mask.
package round_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_LIT    = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   localparam logic [7:0] LFSR_MASK = 8'hB8;

   // Right-shifting Galois step: feedback taps are folded in when the LSB leaves.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

endpackage

// File: rtl/round_arbiter_lfsr8.sv
// 8-bit free-running Galois LFSR used to randomise the lights-off delay.
// SEED must be nonzero or the sequence locks up at zero.
module lfsr8
   import round_arbiter_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] q
);

   logic [7:0] q_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= SEED;
      end else begin
         q_q <= lfsr_next(q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/round_arbiter.sv
// Per-round push arbiter: waits for release, holds lights off for a random
// delay, lights them, and reports the first push (or a jump-the-light).
module round_arbiter
   import round_arbiter_pkg::*;
#(
   parameter int         CNT_W         = 12,
   parameter int         MIN_DLY       = 500,
   parameter int         RELEASE_TICKS = 100,
   parameter int         TIMEOUT_TICKS = 2000,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic pbl,
   input  logic pbr,
   input  logic game_over,
   output logic winrnd,
   output logic right,
   output logic leds_on,
   output logic tie
);

   localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_DLY_C = CNT_W'(MIN_DLY);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] dly_q, dly_d;
   logic             pbl_q, pbr_q;
   logic             winrnd_q, winrnd_d;
   logic             right_q, right_d;
   logic             leds_q, leds_d;
   logic             tie_q, tie_d;
   logic [7:0]       lfsr_q;
   logic             rise_l, rise_r, any_rise;

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr_q)
   );

   assign rise_l   = pbl & ~pbl_q;
   assign rise_r   = pbr & ~pbr_q;
   assign any_rise = rise_l | rise_r;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dly_d    = dly_q;
      winrnd_d = 1'b0;
      right_d  = right_q;
      leds_d   = leds_q;
      tie_d    = tie_q;
      case (state_q)
         ST_IDLE: begin
            if (pbl | pbr) begin
               cnt_d = '0;
            end else if (tick) begin
               // With game_over set the count parks at its last value, so the
               // round starts on the first tick after game_over clears.
               if (cnt_q == REL_LAST) begin
                  if (!game_over) begin
                     state_d = ST_WAIT;
                     cnt_d   = '0;
                     dly_d   = MIN_DLY_C + CNT_W'(lfsr_q);
                     right_d = 1'b0;
                     tie_d   = 1'b0;
                     leds_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT, ST_LIT: begin
            // A push beats a simultaneous delay or timeout expiry.
            if (any_rise) begin
               state_d  = ST_RESULT;
               winrnd_d = 1'b1;
               tie_d    = rise_l & rise_r;
               right_d  = rise_r & ~rise_l;
            end else if (tick) begin
               if (state_q == ST_WAIT && cnt_q == dly_q - 1'b1) begin
                  state_d = ST_LIT;
                  leds_d  = 1'b1;
                  cnt_d   = '0;
               end else if (state_q == ST_LIT && cnt_q == TO_LAST) begin
                  state_d = ST_IDLE;
                  leds_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RESULT: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dly_q    <= '0;
         pbl_q    <= 1'b0;
         pbr_q    <= 1'b0;
         winrnd_q <= 1'b0;
         right_q  <= 1'b0;
         leds_q   <= 1'b0;
         tie_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dly_q    <= dly_d;
         pbl_q    <= pbl;
         pbr_q    <= pbr;
         winrnd_q <= winrnd_d;
         right_q  <= right_d;
         leds_q   <= leds_d;
         tie_q    <= tie_d;
      end
   end

   assign winrnd  = winrnd_q;
   assign right   = right_q;
   assign leds_on = leds_q;
   assign tie     = tie_q;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter with a countdown-based reference model
// checked every cycle, plus hand-computed point checks.
module tb_round_arbiter;

   localparam int         MIN_DLY = 4;
   localparam int         REL     = 2;
   localparam int         TMO     = 10;
   localparam logic [7:0] SEED    = 8'hA5;

   localparam int M_IDLE = 0, M_WAIT = 1, M_LIT = 2, M_RES = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick = 1'b1;
   logic pbl = 1'b0;
   logic pbr = 1'b0;
   logic game_over = 1'b0;
   logic winrnd, right, leds_on, tie;

   int checks = 0;
   int errors = 0;

   round_arbiter #(
      .CNT_W         (12),
      .MIN_DLY       (MIN_DLY),
      .RELEASE_TICKS (REL),
      .TIMEOUT_TICKS (TMO),
      .LFSR_SEED     (SEED)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .pbl       (pbl),
      .pbr       (pbr),
      .game_over (game_over),
      .winrnd    (winrnd),
      .right     (right),
      .leds_on   (leds_on),
      .tie       (tie)
   );

   always #5 clk = ~clk;

   // Reference model: phases with "ticks remaining" countdowns.
   int         m_phase = M_IDLE;
   int         m_left = REL;
   logic [7:0] m_lfsr = SEED;
   logic       m_pl = 1'b0, m_pr = 1'b0, m_rl, m_rr;
   logic       e_win = 1'b0, e_right = 1'b0, e_leds = 1'b0, e_tie = 1'b0;
   bit         m_valid = 1'b0;
   bit         lfsr_forced = 1'b0;

   always @(posedge clk) begin
      m_rl = pbl & ~m_pl;
      m_rr = pbr & ~m_pr;
      if (!rst_n) begin
         m_valid = 1'b1;
         m_phase = M_IDLE;
         m_left  = REL;
         m_lfsr  = SEED;
         m_pl    = 1'b0;
         m_pr    = 1'b0;
         e_win   = 1'b0;
         e_right = 1'b0;
         e_leds  = 1'b0;
         e_tie   = 1'b0;
      end else if (m_valid) begin
         e_win = 1'b0;
         case (m_phase)
            M_IDLE: begin
               if (pbl || pbr) begin
                  m_left = REL;
               end else if (tick) begin
                  if (m_left > 1) begin
                     m_left = m_left - 1;
                  end else if (!game_over) begin
                     m_phase = M_WAIT;
                     m_left  = MIN_DLY + (lfsr_forced ? 0 : int'(m_lfsr));
                     e_right = 1'b0;
                     e_tie   = 1'b0;
                     e_leds  = 1'b0;
                  end
               end
            end
            M_WAIT, M_LIT: begin
               if (m_rl || m_rr) begin
                  m_phase = M_RES;
                  e_win   = 1'b1;
                  e_tie   = m_rl && m_rr;
                  e_right = m_rr && !m_rl;
               end else if (tick) begin
                  if (m_left > 1) begin
                     m_left = m_left - 1;
                  end else if (m_phase == M_WAIT) begin
                     m_phase = M_LIT;
                     e_leds  = 1'b1;
                     m_left  = TMO;
                  end else begin
                     m_phase = M_IDLE;
                     e_leds  = 1'b0;
                     m_left  = REL;
                  end
               end
            end
            default: begin
               m_phase = M_IDLE;
               m_left  = REL;
            end
         endcase
         m_pl   = pbl;
         m_pr   = pbr;
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         checks++;
         if ({winrnd, right, leds_on, tie} !== {e_win, e_right, e_leds, e_tie}) begin
            errors++;
            $display("FAIL model_cmp t=%0t got win=%b right=%b leds=%b tie=%b want win=%b right=%b leds=%b tie=%b",
                     $time, winrnd, right, leds_on, tie, e_win, e_right, e_leds, e_tie);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
      end else begin
         $display("ok   %s t=%0t value %0d", name, $time, act);
      end
   endtask

   task automatic cyc(input logic l, input logic r);
      @(negedge clk);
      rst_n = 1'b1;
      pbl   = l;
      pbr   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      pbl   = 1'b0;
      pbr   = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_verdict(input string name, input int w, input int rt, input int ld, input int t);
      chk({name, "_win"}, int'(winrnd), w);
      chk({name, "_right"}, int'(right), rt);
      chk({name, "_leds"}, int'(leds_on), ld);
      chk({name, "_tie"}, int'(tie), t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t simulation did not finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cycles;
      int seen;
      @(posedge clk);
      #1;
      do_reset();
      chk_verdict("reset0", 0, 0, 0, 0);

      // Free-running LFSR: seed A5 steps to EA before capture, delay 4+234.
      cycles = 0;
      while (!leds_on && cycles < 400) begin
         cyc(0, 0);
         cycles++;
      end
      chk("rand_delay_cycles", cycles, 240);
      cyc(0, 1);
      chk_verdict("rand_push", 1, 1, 1, 0);
      cyc(0, 0);

      // From here on the delay is just MIN_DLY.
      @(negedge clk);
      force dut.lfsr_q = 8'h00;
      lfsr_forced = 1'b1;
      do_reset();
      chk_verdict("reset1", 0, 0, 0, 0);

      // 1: release, wait, lights on after 2+4 cycles
      for (int i = 0; i < 5; i++) cyc(0, 0);
      chk("t1_dark", int'(leds_on), 0);
      cyc(0, 0);
      chk("t1_lit", int'(leds_on), 1);

      // 2: right push one cycle into LIT
      cyc(0, 0);
      cyc(0, 1);
      chk_verdict("t2", 1, 1, 1, 0);
      cyc(0, 1);
      chk("t2_pulse_end", int'(winrnd), 0);
      chk("t2_right_held", int'(right), 1);

      // 3: jump-the-light two cycles into WAIT
      cyc(0, 0);
      cyc(0, 0);
      chk("t3_wait_clears_right", int'(right), 0);
      cyc(0, 0);
      cyc(0, 0);
      cyc(1, 0);
      chk_verdict("t3", 1, 0, 0, 0);
      cyc(1, 0);
      chk("t3_pulse_end", int'(winrnd), 0);

      // 4: tie during LIT
      for (int i = 0; i < 6; i++) cyc(0, 0);
      chk("t4_lit", int'(leds_on), 1);
      cyc(1, 1);
      chk_verdict("t4", 1, 0, 1, 1);
      cyc(0, 0);
      chk("t4_leds_held", int'(leds_on), 1);

      // 5: timeout, then held button blocks the next round
      cyc(0, 0);
      cyc(0, 0);
      chk("t5_wait_clears_leds", int'(leds_on), 0);
      for (int i = 0; i < 4; i++) cyc(0, 0);
      chk("t5_lit", int'(leds_on), 1);
      for (int i = 0; i < 9; i++) cyc(0, 0);
      chk("t5_before_timeout", int'(leds_on), 1);
      cyc(0, 0);
      chk("t5_timeout_leds", int'(leds_on), 0);
      chk("t5_timeout_win", int'(winrnd), 0);
      for (int i = 0; i < 5; i++) cyc(1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0);
      chk("t5_held_dark", int'(leds_on), 0);
      cyc(0, 0);
      chk("t5_relit", int'(leds_on), 1);

      // 6: reset mid-LIT, then game_over blocks new rounds
      do_reset();
      chk_verdict("t6_reset", 0, 0, 0, 0);
      game_over = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(0, 0);
         if (winrnd || leds_on) seen++;
      end
      chk("t6_game_over_block", seen, 0);

      // 7: game_over rising mid-round does not abort it
      game_over = 1'b0;
      cyc(0, 0);
      game_over = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, 0);
      chk("t7_lit_despite_go", int'(leds_on), 1);
      cyc(0, 1);
      chk_verdict("t7", 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0);
      chk("t7_no_restart", int'(leds_on), 1);
      game_over = 1'b0;

      // 8: push on the same cycle the delay expires
      cyc(0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0);
      cyc(1, 0);
      chk_verdict("t8_push_wins", 1, 0, 0, 0);
      cyc(0, 0);

      // 9: half-rate ticks stretch the release and delay counts
      for (int i = 0; i < 12; i++) begin
         tick = (i % 2 == 1);
         cyc(0, 0);
         if (i == 10) chk("t9_dark", int'(leds_on), 0);
         if (i == 11) chk("t9_lit", int'(leds_on), 1);
      end
      tick = 1'b1;
      cyc(0, 1);
      chk_verdict("t9", 1, 1, 1, 0);
      cyc(0, 0);
      cyc(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
